// File: rtl/linkc_tx_if.sv
// linkc_tx_if: flit-link bundle between the NI packetiser, the link
// controller and the router local input port.
//
// Signals
//   data_in        packetiser -> controller flit
//   data_in_valid  single-cycle strobe, one flit per high cycle
//   link_status    controller -> packetiser, 1 = a flit may be launched next cycle
//   flit_out       controller -> router flit
//   flit_out_valid one flit per high cycle
//   credit_in      router -> controller, one pulse per freed buffer slot
//
// Handshake: there is no per-flit ready. The packetiser only launches a flit
// (data_in_valid=1 for one cycle) when it sampled link_status=1; the router
// accepts every flit_out_valid cycle because a credit was consumed for it;
// every credit_in pulse returns exactly one router buffer slot.
//
// Modports
//   master : the link controller (drives link_status and the router side)
//   slave  : the environment (packetiser + router)
interface linkc_tx_if #(
  parameter int FLIT_W = 34
);
  logic [FLIT_W-1:0] data_in;
  logic              data_in_valid;
  logic              link_status;
  logic [FLIT_W-1:0] flit_out;
  logic              flit_out_valid;
  logic              credit_in;

  modport master (
    input  data_in, data_in_valid, credit_in,
    output link_status, flit_out, flit_out_valid
  );

  modport slave (
    output data_in, data_in_valid, credit_in,
    input  link_status, flit_out, flit_out_valid
  );
endinterface

// File: rtl/linkc_tx.sv
// linkc_tx: network-side link controller. Buffers packetiser flits in a small
// FIFO and forwards them to the router local input under credit-based flow
// control (one credit = one free router buffer slot).
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   bus            linkc_tx_if.master (packetiser and router links)
//   overflow_err   sticky: flit arrived while the FIFO was full
//   credit_err     sticky: credit returned while the counter was at CREDITS
//   flits_sent     count of forwarded flits, wraps 0xFFFF -> 0
//   dbg_state      FSM state (0 RESET, 1 IDLE, 2 ACTIVE)
//   dbg_credit_cnt current credit count
//   dbg_occupancy  current FIFO occupancy
module linkc_tx #(
  parameter int FLIT_W     = 34,
  parameter int FIFO_DEPTH = 4,
  parameter int CREDITS    = 4,
  localparam int PTR_W     = $clog2(FIFO_DEPTH),
  localparam int OCC_W     = $clog2(FIFO_DEPTH + 1),
  localparam int CNT_W     = $clog2(CREDITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  linkc_tx_if.master       bus,
  output logic             overflow_err,
  output logic             credit_err,
  output logic [15:0]      flits_sent,
  output logic [1:0]       dbg_state,
  output logic [CNT_W-1:0] dbg_credit_cnt,
  output logic [OCC_W-1:0] dbg_occupancy
);

  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
  // Status stays high only while two slots are free, so a flit launched in
  // the same cycle status falls still finds room.
  localparam logic [OCC_W-1:0] OCC_LINK = OCC_W'(FIFO_DEPTH - 2);
  localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDITS);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [FLIT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [OCC_W-1:0]  occ, occ_nxt;
  logic [CNT_W-1:0]  credit_cnt;
  logic [FLIT_W-1:0] flit_q;
  logic              flit_valid_q;
  logic              link_q, link_nxt;
  logic              ovf_q, cerr_q;
  logic [15:0]       sent_q;

  logic do_write, do_send, drop, credit_inc, credit_sat;

  // Next-state and datapath control. Everything is decided from registered
  // (pre-edge) state, so "full" for a write ignores a pop in the same cycle.
  always_comb begin
    state_nxt  = state;
    do_write   = 1'b0;
    do_send    = 1'b0;
    drop       = 1'b0;
    credit_inc = 1'b0;
    credit_sat = 1'b0;
    occ_nxt    = occ;
    link_nxt   = 1'b0;
    case (state)
      ST_RESET: begin
        // One settling cycle after reset release: no traffic, status low.
        state_nxt = ST_IDLE;
      end
      ST_IDLE, ST_ACTIVE: begin
        do_send    = (state == ST_ACTIVE) && (occ != '0) && (credit_cnt != '0);
        do_write   = bus.data_in_valid && (occ != OCC_FULL);
        drop       = bus.data_in_valid && (occ == OCC_FULL);
        // A credit arriving with a send cancels out; otherwise it refills,
        // saturating at CREDITS and flagging the excess.
        credit_inc = bus.credit_in && !do_send && (credit_cnt != CRED_MAX);
        credit_sat = bus.credit_in && !do_send && (credit_cnt == CRED_MAX);
        case ({do_write, do_send})
          2'b10:   occ_nxt = occ + 1'b1;
          2'b01:   occ_nxt = occ - 1'b1;
          default: occ_nxt = occ;
        endcase
        link_nxt  = (occ_nxt <= OCC_LINK);
        state_nxt = (occ_nxt == '0) ? ST_IDLE : ST_ACTIVE;
      end
      default: state_nxt = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_RESET;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      credit_cnt   <= CRED_MAX;
      flit_q       <= '0;
      flit_valid_q <= 1'b0;
      link_q       <= 1'b0;
      ovf_q        <= 1'b0;
      cerr_q       <= 1'b0;
      sent_q       <= '0;
    end else begin
      flit_valid_q <= do_send;
      occ          <= occ_nxt;
      link_q       <= link_nxt;
      if (do_send) begin
        flit_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
        sent_q <= sent_q + 16'd1;
      end
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (drop) ovf_q <= 1'b1;
      if (do_send && !bus.credit_in) credit_cnt <= credit_cnt - 1'b1;
      else if (credit_inc)           credit_cnt <= credit_cnt + 1'b1;
      if (credit_sat) cerr_q <= 1'b1;
    end
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= bus.data_in;
  end

  assign bus.flit_out       = flit_q;
  assign bus.flit_out_valid = flit_valid_q;
  assign bus.link_status    = link_q;
  assign overflow_err       = ovf_q;
  assign credit_err         = cerr_q;
  assign flits_sent         = sent_q;
  assign dbg_state          = state;
  assign dbg_credit_cnt     = credit_cnt;
  assign dbg_occupancy      = occ;

endmodule

// File: tb/tb_linkc_tx.sv
module tb_linkc_tx;
  localparam int FLIT_W     = 34;
  localparam int FIFO_DEPTH = 4;
  localparam int CREDITS    = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  linkc_tx_if #(.FLIT_W(FLIT_W)) bus ();

  logic        overflow_err, credit_err;
  logic [15:0] flits_sent;
  logic [1:0]  dbg_state;
  logic [2:0]  dbg_credit_cnt;
  logic [2:0]  dbg_occupancy;

  linkc_tx #(.FLIT_W(FLIT_W), .FIFO_DEPTH(FIFO_DEPTH), .CREDITS(CREDITS)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus.master),
    .overflow_err   (overflow_err),
    .credit_err     (credit_err),
    .flits_sent     (flits_sent),
    .dbg_state      (dbg_state),
    .dbg_credit_cnt (dbg_credit_cnt),
    .dbg_occupancy  (dbg_occupancy)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Flits as a queue, credits as an integer; evaluated once per clock edge
  // from the inputs the bench presented before that edge.
  logic [FLIT_W-1:0] exp_q[$];
  int                m_credits = CREDITS;
  bit                m_warm = 1'b0;
  logic [FLIT_W-1:0] m_flit = '0;
  bit                m_valid = 1'b0, m_link = 1'b0, m_ovf = 1'b0, m_cerr = 1'b0;
  logic [15:0]       m_sent = '0;
  int                m_pre;
  bit                m_send;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      m_credits = CREDITS;
      m_warm = 1'b0;
      m_flit = '0;
      m_valid = 1'b0;
      m_link = 1'b0;
      m_ovf = 1'b0;
      m_cerr = 1'b0;
      m_sent = '0;
    end else if (!m_warm) begin
      m_warm = 1'b1;
      m_valid = 1'b0;
      m_link = 1'b0;
    end else begin
      m_pre  = exp_q.size();
      m_send = (m_pre > 0) && (m_credits > 0);
      m_valid = m_send;
      if (m_send) begin
        m_flit = exp_q.pop_front();
        m_sent = m_sent + 16'd1;
      end
      if (bus.data_in_valid) begin
        if (m_pre == FIFO_DEPTH) m_ovf = 1'b1;
        else exp_q.push_back(bus.data_in);
      end
      if (bus.credit_in) begin
        if (!m_send) begin
          if (m_credits == CREDITS) m_cerr = 1'b1;
          else m_credits++;
        end
      end else if (m_send) begin
        m_credits--;
      end
      m_link = (exp_q.size() <= FIFO_DEPTH - 2);
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("flit_out_valid", bus.flit_out_valid, m_valid);
      check("flit_out",       bus.flit_out,       m_flit);
      check("link_status",    bus.link_status,    m_link);
      check("overflow_err",   overflow_err,       m_ovf);
      check("credit_err",     credit_err,         m_cerr);
      check("flits_sent",     flits_sent,         m_sent);
      check("credit_cnt",     dbg_credit_cnt,     m_credits);
      check("occupancy",      dbg_occupancy,      exp_q.size());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send_flit(input logic [FLIT_W-1:0] d);
    bus.data_in = d;
    bus.data_in_valid = 1'b1;
    @(negedge clk);
    bus.data_in_valid = 1'b0;
  endtask

  task automatic pulse_credit();
    bus.credit_in = 1'b1;
    @(negedge clk);
    bus.credit_in = 1'b0;
  endtask

  // Four flits sent with no credit returned leave the credit counter at 0.
  task automatic drain_credits();
    for (int i = 0; i < 4; i++) send_flit(FLIT_W'(34'h0_0000_0200 + i));
    idle(2);
  endtask

  task automatic restore_credits();
    for (int i = 0; i < 4; i++) pulse_credit();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1500000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- main sequence ----------------
  logic [FLIT_W-1:0] seen[$];
  logic [63:0]       rnd;
  int                waited;

  initial begin
    bus.data_in = '0;
    bus.data_in_valid = 1'b0;
    bus.credit_in = 1'b0;

    // Reset, then idle
    @(posedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    check("rst_flit_out_valid", bus.flit_out_valid, 0);
    check("rst_link_status",    bus.link_status,    0);
    check("rst_flits_sent",     flits_sent,         0);
    check("rst_credit_cnt",     dbg_credit_cnt,     4);
    idle(1);
    rst = 1'b1;
    @(negedge clk);
    check("link_first_cycle", bus.link_status, 0);
    @(negedge clk);
    check("link_second_cycle", bus.link_status, 1);
    check("idle_state",        dbg_state,       1);
    check("idle_flits_sent",   flits_sent,      0);

    // Single flit: one cycle latency
    send_flit(34'h2_AAAA_5555);
    check("single_not_yet", bus.flit_out_valid, 0);
    @(negedge clk);
    check("single_valid",   bus.flit_out_valid, 1);
    check("single_flit",    bus.flit_out,       34'h2_AAAA_5555);
    check("single_credits", dbg_credit_cnt,     3);
    check("single_sent",    flits_sent,         1);
    check("model_credits",  m_credits,          3);
    @(negedge clk);
    check("single_once", bus.flit_out_valid, 0);
    pulse_credit();
    check("credit_back", dbg_credit_cnt, 4);

    // Burst of 7 flits, no credits returned: four leave, three stay
    bus.data_in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.data_in = FLIT_W'(34'h0_0000_0100 + i);
      @(negedge clk);
    end
    bus.data_in_valid = 1'b0;
    check("burst_occ",     dbg_occupancy,   3);
    check("burst_link",    bus.link_status, 0);
    check("burst_credits", dbg_credit_cnt,  0);
    check("burst_sent",    flits_sent,      5);
    check("burst_last",    bus.flit_out,    34'h0_0000_0103);
    for (int j = 0; j < 3; j++) begin
      pulse_credit();
      check("credit_wait", bus.flit_out_valid, 0);
      @(negedge clk);
      check("credit_release_valid", bus.flit_out_valid, 1);
      check("credit_release_flit",  bus.flit_out, FLIT_W'(34'h0_0000_0104 + j));
    end
    restore_credits();

    // Credits at 0, five back-to-back flits: fifth dropped
    drain_credits();
    check("drain_credits", dbg_credit_cnt, 0);
    bus.data_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.data_in = FLIT_W'(34'h1_0000_0300 + i);
      @(negedge clk);
    end
    bus.data_in_valid = 1'b0;
    check("full_occ",      dbg_occupancy,   4);
    check("full_overflow", overflow_err,    1);
    check("full_link",     bus.link_status, 0);
    bus.credit_in = 1'b1;
    seen.delete();
    for (int i = 0; i < 7; i++) begin
      if (i == 4) bus.credit_in = 1'b0;
      @(negedge clk);
      if (bus.flit_out_valid) seen.push_back(bus.flit_out);
    end
    check("full_count", seen.size(), 4);
    for (int i = 0; i < 4 && i < seen.size(); i++)
      check("full_order", seen[i], FLIT_W'(34'h1_0000_0300 + i));
    restore_credits();

    // Credit at maximum with empty FIFO, then credit coinciding with a send
    check("max_pre_cerr", credit_err, 0);
    pulse_credit();
    check("max_credits", dbg_credit_cnt, 4);
    check("max_cerr",    credit_err,     1);
    send_flit(34'h3_0000_0400);
    pulse_credit();
    check("cosend_valid",   bus.flit_out_valid, 1);
    check("cosend_flit",    bus.flit_out,       34'h3_0000_0400);
    check("cosend_credits", dbg_credit_cnt,     4);

    // Reset with 3 flits buffered and one credit
    drain_credits();
    bus.data_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.data_in = FLIT_W'(34'h0_0000_0500 + i);
      @(negedge clk);
    end
    bus.data_in_valid = 1'b0;
    pulse_credit();
    check("pre_rst_occ",     dbg_occupancy,  3);
    check("pre_rst_credits", dbg_credit_cnt, 1);
    #2 rst = 1'b0;
    @(negedge clk);
    check("in_rst_occ",     dbg_occupancy,      0);
    check("in_rst_credits", dbg_credit_cnt,     4);
    check("in_rst_valid",   bus.flit_out_valid, 0);
    check("in_rst_ovf",     overflow_err,       0);
    check("in_rst_cerr",    credit_err,         0);
    idle(1);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_flit", bus.flit_out_valid, 0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rnd = {$urandom(), $urandom()};
      bus.data_in = rnd[FLIT_W-1:0];
      bus.data_in_valid = bus.link_status ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
      bus.credit_in = ($urandom_range(0, 2) == 0);
      @(negedge clk);
    end
    bus.data_in_valid = 1'b0;
    bus.credit_in = 1'b0;
    idle(3);

    // Counter wrap: 65535 sends, router returns a credit per received flit
    #2 rst = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(2);
    for (int i = 0; i < 65535; i++) begin
      bus.data_in = FLIT_W'(i);
      bus.data_in_valid = 1'b1;
      bus.credit_in = bus.flit_out_valid;
      @(negedge clk);
    end
    bus.data_in_valid = 1'b0;
    waited = 0;
    while (flits_sent != 16'hFFFF && waited < 20) begin
      bus.credit_in = bus.flit_out_valid;
      @(negedge clk);
      waited++;
    end
    for (int i = 0; i < 3; i++) begin
      bus.credit_in = bus.flit_out_valid;
      @(negedge clk);
    end
    bus.credit_in = 1'b0;
    check("wrap_ffff", flits_sent, 16'hFFFF);
    send_flit(34'h2_0000_FFFF);
    waited = 0;
    while (!bus.flit_out_valid && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("wrap_flit_seen", bus.flit_out_valid, 1);
    check("wrap_zero",      flits_sent,         16'h0000);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
